// File: rtl/temp_threshold_filter_if.sv
`default_nettype none
// ============================================================================
// Module      : temp_threshold_filter_if
// Description : Sample/flag bundle between the temperature sensors, the
//               threshold filter and the downstream temperature FSM.
// Revision    : 1.0 - initial release
// ============================================================================
interface temp_threshold_filter_if;
    logic [7:0] amb_temp;
    logic       amb_valid;
    logic [7:0] corp_temp;
    logic       corp_valid;
    logic       t_25;
    logic       t_27;
    logic       t_30;
    logic       t_corp;
    logic       amb_err;
    logic       corp_err;

    // Sample source side: drives samples, observes flags
    modport master (
        output amb_temp, amb_valid, corp_temp, corp_valid,
        input  t_25, t_27, t_30, t_corp, amb_err, corp_err
    );

    // Filter side: consumes samples, produces flags
    modport slave (
        input  amb_temp, amb_valid, corp_temp, corp_valid,
        output t_25, t_27, t_30, t_corp, amb_err, corp_err
    );
endinterface
`default_nettype wire

// File: rtl/temp_threshold_filter.sv
`default_nettype none
// ============================================================================
// Module      : temp_threshold_filter
// Description : Debounced, hysteretic level flags for ambient and body
//               temperature samples, with a per-channel sample watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module temp_threshold_filter #(
    parameter logic [7:0]  TH_25   = 8'd25,
    parameter logic [7:0]  TH_27   = 8'd27,
    parameter logic [7:0]  TH_30   = 8'd30,
    parameter logic [7:0]  TH_CORP = 8'd38,
    parameter logic [7:0]  HYST    = 8'd1,
    parameter int          NCONF   = 4,
    parameter logic [26:0] TIMEOUT = 27'd100_000_000
) (
    input wire logic                   clk,
    input wire logic                   reset,
    temp_threshold_filter_if.slave     bus
);

    localparam logic [0:0] c_st_off = 1'b0;
    localparam logic [0:0] c_st_on  = 1'b1;
    localparam logic [3:0] c_last   = 4'(NCONF - 1);

    // Channel 0 = ambient, channel 1 = body
    logic [1:0] w_ch_valid;
    logic [1:0] w_ch_expire;
    logic [1:0] w_ch_err;
    logic [3:0] w_flag;

    assign w_ch_valid = {bus.corp_valid, bus.amb_valid};

    for (genvar c = 0; c < 2; c++) begin : g_wd
        logic [26:0] r_wd;
        logic [26:0] w_wd_next;
        logic        r_err;

        // Saturating idle count; expiry holds while the channel stays silent
        assign w_wd_next      = (r_wd == TIMEOUT) ? TIMEOUT : r_wd + 27'd1;
        assign w_ch_expire[c] = !w_ch_valid[c] && (w_wd_next == TIMEOUT);
        assign w_ch_err[c]    = r_err;

        // Watchdog counter and sticky error, cleared by any valid sample
        always_ff @(posedge clk) begin
            if (!reset) begin
                r_wd  <= '0;
                r_err <= 1'b0;
            end else if (w_ch_valid[c]) begin
                r_wd  <= '0;
                r_err <= 1'b0;
            end else begin
                r_wd <= w_wd_next;
                if (w_ch_expire[c]) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_flag
        localparam logic [7:0] c_th  = (g == 0) ? TH_25 :
                                       (g == 1) ? TH_27 :
                                       (g == 2) ? TH_30 : TH_CORP;
        // Release level; HYST <= threshold so this never wraps
        localparam logic [7:0] c_rel = c_th - HYST;
        localparam int         c_ch  = (g == 3) ? 1 : 0;

        logic [7:0] w_temp;
        logic       w_qual;
        logic [0:0] r_state;
        logic [0:0] w_state_next;
        logic [3:0] r_cnt;
        logic [3:0] w_cnt_next;

        assign w_temp = (c_ch == 1) ? bus.corp_temp : bus.amb_temp;
        // Qualifying sample: rising above threshold when OFF, below release when ON
        assign w_qual = (r_state == c_st_on) ? (w_temp < c_rel) : (w_temp >= c_th);

        // Next state/confirm count: watchdog expiry overrides sample processing
        always_comb begin
            w_state_next = r_state;
            w_cnt_next   = r_cnt;
            if (w_ch_expire[c_ch]) begin
                w_state_next = c_st_off;
                w_cnt_next   = '0;
            end else if (w_ch_valid[c_ch]) begin
                if (!w_qual) begin
                    w_cnt_next = '0;
                end else if (r_cnt == c_last) begin
                    w_state_next = ~r_state;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 4'd1;
                end
            end
        end

        // Flag state and confirm counter registers
        always_ff @(posedge clk) begin
            if (!reset) begin
                r_state <= c_st_off;
                r_cnt   <= '0;
            end else begin
                r_state <= w_state_next;
                r_cnt   <= w_cnt_next;
            end
        end

        assign w_flag[g] = (r_state == c_st_on);
    end

    assign bus.t_25     = w_flag[0];
    assign bus.t_27     = w_flag[1];
    assign bus.t_30     = w_flag[2];
    assign bus.t_corp   = w_flag[3];
    assign bus.amb_err  = w_ch_err[0];
    assign bus.corp_err = w_ch_err[1];

endmodule
`default_nettype wire

// File: tb/tb_temp_threshold_filter.sv
`default_nettype none
// ============================================================================
// Module      : tb_temp_threshold_filter
// Description : Self-checking bench for temp_threshold_filter: directed
//               scenarios plus randomized samples against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_temp_threshold_filter;

    localparam int NCONF   = 4;
    localparam int TIMEOUT = 50;
    localparam int HYST    = 1;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    temp_threshold_filter_if bus ();

    temp_threshold_filter #(
        .NCONF   (NCONF),
        .TIMEOUT (27'(TIMEOUT))
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: each flag toggles once NCONF consecutive samples since
    // its last change satisfy the current direction's rule.
    int  th [4] = '{25, 27, 30, 38};
    bit  m_flag [4];
    int  m_hist [4][$];
    int  m_idle [2];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic model_update(input bit rst_n, input bit av, input int at,
                                input bit cv, input int ct);
        bit v [2];
        int t [2];
        v[0] = av; v[1] = cv; t[0] = at; t[1] = ct;
        if (!rst_n) begin
            for (int f = 0; f < 4; f++) begin
                m_flag[f] = 0;
                m_hist[f].delete();
            end
            m_idle[0] = 0;
            m_idle[1] = 0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (v[c]) m_idle[c] = 0;
                else if (m_idle[c] < TIMEOUT) m_idle[c]++;
            end
            for (int f = 0; f < 4; f++) begin
                int  c;
                bit  qual;
                c = (f == 3) ? 1 : 0;
                if (v[c]) begin
                    qual = m_flag[f] ? (t[c] < th[f] - HYST) : (t[c] >= th[f]);
                    if (qual) m_hist[f].push_back(t[c]);
                    else      m_hist[f].delete();
                    if (m_hist[f].size() == NCONF) begin
                        m_flag[f] = !m_flag[f];
                        m_hist[f].delete();
                    end
                end else if (m_idle[c] == TIMEOUT) begin
                    m_flag[f] = 0;
                    m_hist[f].delete();
                end
            end
        end
    endtask

    function automatic logic [5:0] outs_act();
        return {bus.amb_err, bus.corp_err, bus.t_corp, bus.t_30, bus.t_27, bus.t_25};
    endfunction

    function automatic logic [5:0] outs_exp();
        return {m_idle[0] == TIMEOUT, m_idle[1] == TIMEOUT,
                m_flag[3], m_flag[2], m_flag[1], m_flag[0]};
    endfunction

    // One clock: drive on the falling edge, model the rising edge, check after it
    task automatic step(input bit rst_n, input bit av, input int at,
                        input bit cv, input int ct);
        @(negedge clk);
        reset          = rst_n;
        bus.amb_valid  = av;
        bus.amb_temp   = 8'(at);
        bus.corp_valid = cv;
        bus.corp_temp  = 8'(ct);
        @(posedge clk);
        model_update(rst_n, av, at, cv, ct);
        #1;
        check("outs", 32'(outs_act()), 32'(outs_exp()));
    endtask

    task automatic amb(input int t, input int n);
        for (int i = 0; i < n; i++) step(1, 1, t, 0, 0);
    endtask

    task automatic corp(input int t, input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 1, t);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL sim_timeout actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        reset          = 1'b0;
        bus.amb_valid  = 1'b0;
        bus.amb_temp   = '0;
        bus.corp_valid = 1'b0;
        bus.corp_temp  = '0;

        // Reset dominates valid strobes
        for (int i = 0; i < 6; i++) step(0, 1, 40, 1, 40);
        check("reset_outs", 32'(outs_act()), 32'h0);

        // Four ambient 28s raise t_25 and t_27 only
        amb(28, 3);
        check("t25_before4", 32'(bus.t_25), 32'h0);
        amb(28, 1);
        check("t25_after4", 32'(bus.t_25), 32'h1);
        check("t27_after4", 32'(bus.t_27), 32'h1);
        check("t30_after4", 32'(bus.t_30), 32'h0);

        // Broken run never confirms
        step(0, 0, 0, 0, 0);
        amb(28, 3);
        amb(24, 1);
        amb(28, 3);
        check("broken_run", 32'(outs_act()), 32'h0);
        amb(28, 1);
        check("run_completes", 32'({bus.t_27, bus.t_25}), 32'h3);

        // Hysteresis band holds, release below band drops t_27 only
        amb(26, 10);
        check("band_hold_t27", 32'(bus.t_27), 32'h1);
        amb(25, 3);
        check("release_3_t27", 32'(bus.t_27), 32'h1);
        amb(25, 1);
        check("release_4_t27", 32'(bus.t_27), 32'h0);
        check("release_4_t25", 32'(bus.t_25), 32'h1);

        // Body channel independent of ambient flags
        corp(39, 4);
        check("tcorp_on", 32'(bus.t_corp), 32'h1);
        check("amb_unaffected", 32'({bus.t_30, bus.t_27, bus.t_25}), 32'h1);

        // Ambient watchdog
        amb(31, 4);
        check("t30_on", 32'(bus.t_30), 32'h1);
        for (int i = 0; i < TIMEOUT - 1; i++) step(1, 0, 0, 0, 0);
        check("wd_before", 32'({bus.amb_err, bus.t_30}), 32'h1);
        step(1, 0, 0, 0, 0);
        check("wd_expired", 32'({bus.amb_err, bus.t_30, bus.t_27, bus.t_25}), 32'h8);
        amb(31, 1);
        check("wd_cleared", 32'({bus.amb_err, bus.t_30}), 32'h0);
        amb(31, 2);
        check("wd_t30_3", 32'(bus.t_30), 32'h0);
        amb(31, 1);
        check("wd_t30_4", 32'(bus.t_30), 32'h1);

        // Reset mid-confirm restarts the count
        step(0, 0, 0, 0, 0);
        amb(31, 2);
        step(0, 0, 0, 0, 0);
        amb(31, 3);
        check("rst_mid_3", 32'(bus.t_25), 32'h0);
        amb(31, 1);
        check("rst_mid_4", 32'(bus.t_25), 32'h1);

        // Randomized phases with varying strobe density
        for (int p = 0; p < 8; p++) begin
            int dens;
            dens = (p % 3 == 2) ? 3 : 60;
            for (int i = 0; i < 120; i++) begin
                bit rn, av, cv;
                rn = ($urandom_range(0, 199) != 0);
                av = ($urandom_range(0, 99) < dens);
                cv = ($urandom_range(0, 99) < dens);
                step(rn, av, int'($urandom_range(20, 42)), cv, int'($urandom_range(30, 45)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
